prll_bs_rr_sched_6drvrs: RTL and testbench

Round-robin scheduler and router for the 6-driver single parallel bus. It arbitrates between the drivers' pending transmit FIFOs and pops one packet at a time from the granted driver. It decodes the destination field and pushes the packet to the addressed driver, or to every other driver on broadcast. It sits between the per-driver FIFOs and the bus generator/arbiter wrapper and owns all pop/push sequencing on bus 0.

---
 rtl/prll_bs_rr_sched_6drvrs.sv | 158 +++++++++++++++
 tb/tb_prll_bs_rr_sched_6drvrs.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prll_bs_rr_sched_6drvrs.sv
// Round-robin scheduler/router for the 6-driver parallel bus: pops one packet
// from the granted driver FIFO and pushes it to its destination driver(s).
module prll_bs_rr_sched_6drvrs #(
    parameter int unsigned bits      = 256,
    parameter int unsigned drvrs     = 6,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [drvrs-1:0]        pndng,
    input  logic [drvrs*bits-1:0]   D_pop,
    output logic [drvrs-1:0]        pop,
    output logic [drvrs-1:0]        push,
    output logic [bits-1:0]         D_push,
    output logic                    busy,
    output logic [15:0]             drop_cnt
);

    localparam int unsigned GW    = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam int unsigned DST_W = 8;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_grant_q, last_grant_d;
    logic [bits-1:0]  data_q, data_d;
    logic [drvrs-1:0] mask_q, mask_d;
    logic [drvrs-1:0] push_q, push_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [bits-1:0]  head_word;
    logic [drvrs-1:0] gnt_oh;
    logic [DST_W-1:0] dst;
    logic [drvrs-1:0] route_mask;
    logic             dst_bad;
    logic             pndng_gnt;
    logic             found;

    // Head word and one-hot of the current grant.
    always_comb begin
        head_word = '0;
        gnt_oh    = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (grant_q == GW'(i)) begin
                head_word = D_pop[i*bits +: bits];
                gnt_oh[i] = 1'b1;
            end
        end
    end

    assign dst       = head_word[bits-1 -: DST_W];
    assign pndng_gnt = |(pndng & gnt_oh);

    // Destination decode; broadcast excludes the source driver.
    always_comb begin
        route_mask = '0;
        dst_bad    = 1'b0;
        if (dst == broadcast) begin
            route_mask = ~gnt_oh;
        end else if (dst < DST_W'(drvrs)) begin
            for (int i = 0; i < drvrs; i++) begin
                route_mask[i] = (dst == DST_W'(i));
            end
        end else begin
            dst_bad = 1'b1;
        end
    end

    // Next-state and strobe logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        mask_d       = mask_q;
        drop_cnt_d   = drop_cnt_q;
        push_d       = '0;
        pop          = '0;
        found        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|pndng) begin
                    // Search above last_grant first, then wrap to the bottom.
                    for (int i = 0; i < drvrs; i++) begin
                        if (!found && pndng[i] && (GW'(i) > last_grant_q)) begin
                            found   = 1'b1;
                            grant_d = GW'(i);
                        end
                    end
                    for (int i = 0; i < drvrs; i++) begin
                        if (!found && pndng[i]) begin
                            found   = 1'b1;
                            grant_d = GW'(i);
                        end
                    end
                    last_grant_d = grant_d;
                    state_d      = S_POP;
                end
            end
            S_POP: begin
                if (pndng_gnt) begin
                    pop    = gnt_oh;
                    data_d = head_word;
                    mask_d = route_mask;
                    push_d = route_mask;
                    if (dst_bad && (drop_cnt_q != {CNT_W{1'b1}})) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    end
                    state_d = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(drvrs - 1);
            data_q       <= '0;
            mask_q       <= '0;
            push_q       <= '0;
            busy_q       <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            push_q       <= push_d;
            busy_q       <= busy_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign push     = push_q;
    assign D_push   = data_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_prll_bs_rr_sched_6drvrs.sv
// Directed bench for prll_bs_rr_sched_6drvrs with a small per-driver FIFO model.
module tb_prll_bs_rr_sched_6drvrs;

    localparam int unsigned BITS = 256;
    localparam int unsigned ND   = 6;
    localparam int unsigned QD   = 8;

    logic               clk;
    logic               reset;
    logic [ND-1:0]      pndng;
    logic [ND*BITS-1:0] D_pop;
    logic [ND-1:0]      pop;
    logic [ND-1:0]      push;
    logic [BITS-1:0]    D_push;
    logic               busy;
    logic [15:0]        drop_cnt;

    logic [BITS-1:0] q_mem [ND][QD];
    int              q_cnt [ND];
    logic [ND-1:0]   hold;

    int n_chk;
    int n_pass;

    prll_bs_rr_sched_6drvrs dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BITS-1:0] mkpkt(input logic [7:0] d, input logic [31:0] p);
        return {d, 248'(p)};
    endfunction

    task automatic refresh();
        for (int i = 0; i < ND; i++) begin
            pndng[i] = (q_cnt[i] > 0) && !hold[i];
            D_pop[i*BITS +: BITS] = (q_cnt[i] > 0) ? q_mem[i][0] : '0;
        end
    endtask

    task automatic enq(input int d, input logic [BITS-1:0] w);
        q_mem[d][q_cnt[d]] = w;
        q_cnt[d] = q_cnt[d] + 1;
    endtask

    task automatic clear_q();
        for (int i = 0; i < ND; i++) q_cnt[i] = 0;
        hold = '0;
    endtask

    // Advance one clock; FIFOs pop on the edge that ends a cycle with pop high.
    task automatic tick();
        logic [ND-1:0] ps;
        @(negedge clk);
        ps = pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            if (ps[i] && q_cnt[i] > 0) begin
                for (int k = 0; k < QD - 1; k++) q_mem[i][k] = q_mem[i][k+1];
                q_cnt[i] = q_cnt[i] - 1;
            end
        end
        refresh();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_q();
        refresh();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_q();
        refresh();
        @(posedge clk);
        #1;
        n_chk++; if (pop !== 6'b0)      $display("FAIL reset_pop: got %b exp 000000", pop);      else n_pass++;
        n_chk++; if (push !== 6'b0)     $display("FAIL reset_push: got %b exp 000000", push);    else n_pass++;
        n_chk++; if (D_push !== '0)     $display("FAIL reset_dpush: got %h exp 0", D_push);      else n_pass++;
        n_chk++; if (busy !== 1'b0)     $display("FAIL reset_busy: got %b exp 0", busy);         else n_pass++;
        n_chk++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d exp 0", drop_cnt);   else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [BITS-1:0] w;
        w = mkpkt(8'h04, 32'hABCD);
        enq(2, w);
        refresh();
        tick();
        n_chk++; if (pop !== 6'b000100) $display("FAIL single_pop: got %b exp 000100", pop);     else n_pass++;
        n_chk++; if (busy !== 1'b1)     $display("FAIL single_busy_c1: got %b exp 1", busy);     else n_pass++;
        n_chk++; if (push !== 6'b0)     $display("FAIL single_push_c1: got %b exp 000000", push); else n_pass++;
        tick();
        n_chk++; if (push !== 6'b010000) $display("FAIL single_push: got %b exp 010000", push);  else n_pass++;
        n_chk++; if (D_push !== w)       $display("FAIL single_dpush: got %h exp %h", D_push, w); else n_pass++;
        n_chk++; if (D_push[255:248] !== 8'h04) $display("FAIL single_dst: got %h exp 04", D_push[255:248]); else n_pass++;
        n_chk++; if (pop !== 6'b0)       $display("FAIL single_pop_c2: got %b exp 000000", pop); else n_pass++;
        n_chk++; if (busy !== 1'b1)      $display("FAIL single_busy_c2: got %b exp 1", busy);    else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0)      $display("FAIL single_busy_c3: got %b exp 0", busy);    else n_pass++;
        n_chk++; if (push !== 6'b0)      $display("FAIL single_push_c3: got %b exp 000000", push); else n_pass++;
    endtask

    task automatic test_round_robin();
        int              exp_g [6] = '{0, 1, 5, 0, 1, 5};
        logic [7:0]      dsts [6]  = '{8'd3, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        logic [BITS-1:0] w;
        logic [ND-1:0]   oh;
        logic [ND-1:0]   dm;
        int              cyc;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            enq(0, mkpkt(dsts[0], 32'h000 + 32'(k)));
            enq(1, mkpkt(dsts[1], 32'h100 + 32'(k)));
            enq(5, mkpkt(dsts[5], 32'h500 + 32'(k)));
        end
        refresh();
        cyc = 0;
        for (int j = 0; j < 6; j++) begin
            oh = '0;
            oh[exp_g[j]] = 1'b1;
            dm = '0;
            dm[dsts[exp_g[j]]] = 1'b1;
            w = mkpkt(dsts[exp_g[j]], 32'(exp_g[j] * 256 + j / 3));
            tick(); cyc++;
            n_chk++; if (pop !== oh) $display("FAIL rr_pop%0d: got %b exp %b", j, pop, oh); else n_pass++;
            tick(); cyc++;
            n_chk++; if (push !== dm) $display("FAIL rr_push%0d: got %b exp %b", j, push, dm); else n_pass++;
            n_chk++; if (D_push !== w) $display("FAIL rr_data%0d: got %h exp %h", j, D_push, w); else n_pass++;
            tick(); cyc++;
            n_chk++; if (busy !== 1'b0) $display("FAIL rr_idle%0d: got busy %b exp 0", j, busy); else n_pass++;
        end
        n_chk++; if (pndng !== 6'b0 || cyc != 18) $display("FAIL rr_drain: pndng %b after %0d cycles exp 000000 after 18", pndng, cyc); else n_pass++;
    endtask

    task automatic test_broadcast();
        enq(3, mkpkt(8'hFF, 32'h33));
        refresh();
        tick();
        n_chk++; if (pop !== 6'b001000)  $display("FAIL bc_pop: got %b exp 001000", pop);   else n_pass++;
        tick();
        n_chk++; if (push !== 6'b110111) $display("FAIL bc_push: got %b exp 110111", push); else n_pass++;
        tick();
        n_chk++; if (push !== 6'b0)      $display("FAIL bc_push_after: got %b exp 000000", push); else n_pass++;
    endtask

    task automatic test_drop();
        enq(1, mkpkt(8'h09, 32'h99));
        refresh();
        tick();
        n_chk++; if (pop !== 6'b000010)  $display("FAIL drop_pop: got %b exp 000010", pop);    else n_pass++;
        n_chk++; if (drop_cnt !== 16'd0) $display("FAIL drop_cnt0: got %0d exp 0", drop_cnt);  else n_pass++;
        tick();
        n_chk++; if (push !== 6'b0)      $display("FAIL drop_push: got %b exp 000000", push);  else n_pass++;
        n_chk++; if (drop_cnt !== 16'd1) $display("FAIL drop_cnt1: got %0d exp 1", drop_cnt);  else n_pass++;
        tick();
        // Preload the counter just below saturation.
        force dut.drop_cnt_q = 16'hFFFE;
        #1;
        release dut.drop_cnt_q;
        enq(1, mkpkt(8'h09, 32'h9A));
        enq(1, mkpkt(8'h07, 32'h9B));
        enq(1, mkpkt(8'h02, 32'h9C));
        refresh();
        tick(); tick();
        n_chk++; if (drop_cnt !== 16'hFFFF) $display("FAIL drop_sat1: got %h exp ffff", drop_cnt); else n_pass++;
        tick(); tick(); tick();
        n_chk++; if (drop_cnt !== 16'hFFFF) $display("FAIL drop_sat2: got %h exp ffff", drop_cnt); else n_pass++;
        n_chk++; if (push !== 6'b0)         $display("FAIL drop_push2: got %b exp 000000", push);  else n_pass++;
        tick(); tick(); tick();
        n_chk++; if (push !== 6'b000100)    $display("FAIL drop_valid_push: got %b exp 000100", push); else n_pass++;
        n_chk++; if (drop_cnt !== 16'hFFFF) $display("FAIL drop_sat3: got %h exp ffff", drop_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        enq(4, mkpkt(8'h00, 32'h44));
        refresh();
        tick();
        n_chk++; if (pop !== 6'b010000) $display("FAIL rmid_pop: got %b exp 010000", pop);  else n_pass++;
        tick();
        n_chk++; if (push !== 6'b000001) $display("FAIL rmid_push: got %b exp 000001", push); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_chk++; if (push !== 6'b0)  $display("FAIL rmid_push_rst: got %b exp 000000", push); else n_pass++;
        n_chk++; if (busy !== 1'b0)  $display("FAIL rmid_busy_rst: got %b exp 0", busy);      else n_pass++;
        n_chk++; if (D_push !== '0)  $display("FAIL rmid_dpush_rst: got %h exp 0", D_push);   else n_pass++;
        for (int i = 0; i < ND; i++) enq(i, mkpkt(8'h02, 32'h700 + 32'(i)));
        refresh();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_chk++; if (pop !== 6'b000001) $display("FAIL rmid_first_pop: got %b exp 000001", pop); else n_pass++;
    endtask

    task automatic test_pndng_drop();
        apply_reset();
        enq(5, mkpkt(8'h09, 32'h55));
        refresh();
        tick();
        n_chk++; if (pop !== 6'b100000) $display("FAIL pd_pop_before: got %b exp 100000", pop); else n_pass++;
        hold = 6'b100000;
        refresh();
        #1;
        n_chk++; if (pop !== 6'b0) $display("FAIL pd_pop_gated: got %b exp 000000", pop); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0)      $display("FAIL pd_busy: got %b exp 0", busy);       else n_pass++;
        n_chk++; if (push !== 6'b0)      $display("FAIL pd_push: got %b exp 000000", push);  else n_pass++;
        n_chk++; if (drop_cnt !== 16'd0) $display("FAIL pd_drop: got %0d exp 0", drop_cnt);  else n_pass++;
        n_chk++; if (D_push !== '0)      $display("FAIL pd_nocap: got %h exp 0", D_push);    else n_pass++;
        hold = '0;
        refresh();
        tick();
        n_chk++; if (pop !== 6'b100000)  $display("FAIL pd_retry_pop: got %b exp 100000", pop); else n_pass++;
        tick();
        n_chk++; if (drop_cnt !== 16'd1) $display("FAIL pd_retry_drop: got %0d exp 1", drop_cnt); else n_pass++;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_broadcast();
        test_drop();
        test_reset_mid();
        test_pndng_drop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
